// File: rtl/mux_select_sequencer.sv
// Serializes one accepted 8-bit word by stepping the 8:1 mux select through all
// bit positions, one position per CLK_DIV-cycle bit period, with bit framing.
module mux_select_sequencer #(
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] word,
  output logic [3:0] select,
  output logic       bit_valid,
  output logic       bit_last,
  output logic       done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       word_reg;
  logic [3:0]       select_reg;
  logic             bit_valid_reg;
  logic             bit_last_reg;
  logic             done_reg;

  logic period_end;
  logic word_end;
  logic accept;

  function automatic logic [3:0] sel_of(input logic [2:0] idx);
    return MSB_FIRST ? {1'b0, 3'd7 - idx} : {1'b0, idx};
  endfunction

  assign period_end = (div_cnt_reg == DIV_LAST);
  assign word_end   = (state_reg == SHIFT) && period_end && (bit_cnt_reg == 3'd7);

  // Ready on the final bit cycle too, so a new word follows with no bubble;
  // an abort on that cycle wins and refuses the offered word.
  assign in_ready = !rst && ((state_reg == IDLE) || (word_end && !abort));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      word_reg      <= '0;
      select_reg    <= '0;
      bit_valid_reg <= 1'b0;
      bit_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        state_reg     <= SHIFT;
        word_reg      <= in_data;
        div_cnt_reg   <= '0;
        bit_cnt_reg   <= '0;
        select_reg    <= sel_of(3'd0);
        bit_valid_reg <= 1'b1;
        bit_last_reg  <= 1'b0;
        done_reg      <= word_end;
      end else if (state_reg == SHIFT) begin
        if (abort || word_end) begin
          state_reg     <= IDLE;
          bit_valid_reg <= 1'b0;
          bit_last_reg  <= 1'b0;
          done_reg      <= !abort;
        end else if (period_end) begin
          div_cnt_reg  <= '0;
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          select_reg   <= sel_of(bit_cnt_reg + 3'd1);
          bit_last_reg <= (bit_cnt_reg == 3'd6);
        end else begin
          div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
      end
    end
  end

  assign word      = word_reg;
  assign select    = select_reg;
  assign bit_valid = bit_valid_reg;
  assign bit_last  = bit_last_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench: three sequencer instances (div1/LSB, div3/MSB, div2/LSB) driven
// from a vector table plus hand-written multi-cycle sequences.
module tb_mux_select_sequencer;

  logic       clk;
  logic       rst       [3];
  logic [7:0] in_data   [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       abort     [3];
  logic [7:0] word      [3];
  logic [3:0] select    [3];
  logic       bit_valid [3];
  logic       bit_last  [3];
  logic       done      [3];

  int compared   = 0;
  int mismatched = 0;

  mux_select_sequencer #(.CLK_DIV(1), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .abort(abort[0]), .word(word[0]), .select(select[0]),
    .bit_valid(bit_valid[0]), .bit_last(bit_last[0]), .done(done[0]));

  mux_select_sequencer #(.CLK_DIV(3), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .abort(abort[1]), .word(word[1]), .select(select[1]),
    .bit_valid(bit_valid[1]), .bit_last(bit_last[1]), .done(done[1]));

  mux_select_sequencer #(.CLK_DIV(2), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .abort(abort[2]), .word(word[2]), .select(select[2]),
    .bit_valid(bit_valid[2]), .bit_last(bit_last[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic       v;
    logic [7:0] d;
    logic       ab;
    logic       e_valid;
    logic [3:0] e_sel;
    logic       e_last;
    logic       e_done;
    logic       e_ready;
    logic       e_mux;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int dut, input logic v, input logic [7:0] d,
                              input logic ab, input logic ev, input logic [3:0] es,
                              input logic el, input logic ed, input logic er,
                              input logic em);
    vec_t r;
    r.dut = dut; r.v = v; r.d = d; r.ab = ab;
    r.e_valid = ev; r.e_sel = es; r.e_last = el; r.e_done = ed;
    r.e_ready = er; r.e_mux = em;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic mux_out(input int u);
    return word[u][select[u][2:0]];
  endfunction

  // Drive one cycle of inputs on the falling edge; outputs are sampled 1 ns later.
  task automatic step(input int u, input logic r, input logic v, input logic [7:0] d,
                      input logic ab);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      rst[j] = 1'b0; in_valid[j] = 1'b0; in_data[j] = 8'h00; abort[j] = 1'b0;
    end
    rst[u] = r; in_valid[u] = v; in_data[u] = d; abort[u] = ab;
    #1;
  endtask

  task automatic check_outs(input int u, input string tag, input logic ev,
                            input logic [3:0] es, input logic el, input logic ed,
                            input logic er, input logic em);
    chk({tag, ".bit_valid"}, bit_valid[u], ev);
    chk({tag, ".select"},    select[u],    es);
    chk({tag, ".bit_last"},  bit_last[u],  el);
    chk({tag, ".done"},      done[u],      ed);
    chk({tag, ".in_ready"},  in_ready[u],  er);
    chk({tag, ".mux"},       mux_out(u),   em);
  endtask

  initial begin
    logic [7:0] w;
    logic       lc;

    // ---- Vector table: u0 basic LSB + back-to-back; u2 abort cases ----
    w = 8'hA5;
    add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 0, 1, 4'(k), k == 7, 0, k == 7, w[k]);
    add(0, 0, 8'h00, 0, 0, 7, 0, 1, 1, w[7]);
    add(0, 0, 8'h00, 0, 0, 7, 0, 0, 1, w[7]);
    add(0, 1, 8'hFF, 0, 0, 7, 0, 0, 1, 1);
    for (int k = 0; k < 8; k++) add(0, 1, 8'h00, 0, 1, 4'(k), k == 7, 0, k == 7, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 0, 1, 4'(k), k == 7, k == 0, k == 7, 0);
    add(0, 0, 8'h00, 0, 0, 7, 0, 1, 1, 0);
    add(0, 0, 8'h00, 0, 0, 7, 0, 0, 1, 0);

    w = 8'h3C;
    add(2, 1, 8'h3C, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) add(2, 0, 8'h00, 0, 1, 4'(k), 0, 0, 0, w[k]);
    add(2, 1, 8'h55, 1, 1, 3, 0, 0, 0, w[3]);
    add(2, 0, 8'h00, 0, 0, 3, 0, 0, 1, w[3]);
    add(2, 1, 8'h96, 1, 0, 3, 0, 0, 1, w[3]);
    w = 8'h96;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 2; c++)
        add(2, 0, 8'h00, 0, 1, 4'(k), k == 7, 0, (k == 7) && (c == 1), w[k]);
    add(2, 0, 8'h00, 0, 0, 7, 0, 1, 1, w[7]);
    add(2, 1, 8'hF0, 0, 0, 7, 0, 0, 1, w[7]);
    w = 8'hF0;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 2; c++) begin
        lc = (k == 7) && (c == 1);
        add(2, lc, 8'h0F, lc, 1, 4'(k), k == 7, 0, 0, w[k]);
      end
    add(2, 0, 8'h00, 0, 0, 7, 0, 0, 1, w[7]);

    // ---- Reset ----
    for (int j = 0; j < 3; j++) begin
      rst[j] = 1'b1; in_valid[j] = 1'b0; in_data[j] = 8'h00; abort[j] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst%0d.word", u), word[u], 8'h00);
      check_outs(u, $sformatf("rst%0d", u), 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 8'h00, 0);
    for (int u = 0; u < 3; u++) chk($sformatf("post_rst%0d.in_ready", u), in_ready[u], 1);

    // ---- Stalled producer on u1, in_data toggling ----
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, i[0] ? 8'hFF : 8'h5A, 0);
      check_outs(1, $sformatf("stall%0d", i), 0, 0, 0, 0, 1, 0);
      chk($sformatf("stall%0d.word", i), word[1], 8'h00);
    end

    // ---- MSB-first, CLK_DIV=3 on u1 ----
    step(1, 0, 1, 8'h81, 0);
    check_outs(1, "msb_acc", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 0, 8'h7E, 0);
      check_outs(1, $sformatf("msb%0d", i), 1, 4'(7 - i / 3), i >= 21, 0, i == 23,
                 (i < 3) || (i >= 21));
    end
    step(1, 0, 0, 8'h00, 0);
    check_outs(1, "msb_end", 0, 0, 0, 1, 1, 1);
    chk("msb_end.word", word[1], 8'h81);

    // ---- Table ----
    foreach (tbl[i]) begin
      step(tbl[i].dut, 0, tbl[i].v, tbl[i].d, tbl[i].ab);
      check_outs(tbl[i].dut, $sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_sel,
                 tbl[i].e_last, tbl[i].e_done, tbl[i].e_ready, tbl[i].e_mux);
    end

    // ---- Reset mid-word on u0 ----
    step(0, 0, 1, 8'hFF, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 8'h00, 0);
      chk($sformatf("mid%0d.select", k), select[0], 4'(k));
    end
    step(0, 1, 0, 8'h00, 0);
    check_outs(0, "mid_b5", 1, 5, 0, 0, 0, 1);
    step(0, 1, 0, 8'h00, 0);
    chk("mid_rst.word", word[0], 8'h00);
    check_outs(0, "mid_rst", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0);
    check_outs(0, "mid_rel", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 8'h00, 0);
    check_outs(0, "mid_rel2", 0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Upstream driver for the 8:1 bit-select multiplexer. Accepts one 8-bit word over a valid/ready handshake and holds it on `word`, which connects to the mux `in[7:0]`.
- Steps `select` through all eight bit positions, one position per bit period, so the mux output becomes a serial bitstream.
- Provides framing (`bit_valid`, `bit_last`, `done`) for the downstream consumer of the mux output.

Parameters:
- CLK_DIV, 1: clock cycles per bit period; legal range 1..65535.
- MSB_FIRST, 0: 0 = select sequence 0→7; 1 = select sequence 7→0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept a word this cycle.
- abort  input  1  synchronous abort of the current word.
- word  output  8  held word; drives mux in[7:0].
- select  output  4  bit index to mux; bit 3 always 0.
- bit_valid  output  1  current select/word pair is a live bit.
- bit_last  output  1  current bit period is the 8th bit.
- done  output  1  one-cycle pulse after the 8th bit completes.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst); no asynchronous logic.
- Reset (rst=1 at an edge):
  - state=IDLE; word=0; select=0; bit_valid=0; bit_last=0; done=0.
  - div_cnt=0; bit_cnt=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after reset.
  - Reset mid-word discards the word with no done pulse.
- State IDLE:
  - in_ready=1; bit_valid=0; select holds its last value.
  - Handshake: in_valid & in_ready at an edge → word<=in_data; bit_cnt<=0; div_cnt<=0; state<=SHIFT.
- State SHIFT:
  - bit_valid=1.
  - select = {1'b0, bit_cnt} if MSB_FIRST=0; {1'b0, 3'd7-bit_cnt} if MSB_FIRST=1.
  - Each bit period lasts CLK_DIV cycles: div_cnt counts 0..CLK_DIV-1, then wraps to 0 and bit_cnt increments.
  - bit_last=1 for all CLK_DIV cycles where bit_cnt==7.
  - word is stable for the whole SHIFT; in_data changes are ignored.
- Latency:
  - First bit valid the cycle after acceptance.
  - A word occupies exactly 8×CLK_DIV cycles of bit_valid.
- Completion: at the edge ending the last cycle of bit 7 (bit_cnt==7, div_cnt==CLK_DIV-1):
  - done<=1 for exactly one cycle.
  - Without a new acceptance: state<=IDLE, bit_valid<=0.
- Back-to-back:
  - in_ready is also 1 on the final cycle of bit 7.
  - A handshake on that cycle loads the new word, resets the counters and stays in SHIFT, with no bubble: bit_valid stays 1 across the boundary.
  - done still pulses for the finished word.
  - in_ready=0 on every other SHIFT cycle.
- Abort:
  - abort=1 in SHIFT at an edge → state<=IDLE; bit_valid<=0; bit_last<=0; no done pulse.
  - abort has priority over completion and over a back-to-back handshake on the same cycle; the offered word is not accepted.
  - abort in IDLE has no effect; a handshake in the same cycle still proceeds.
- Priority: rst > abort > completion/handshake > counting.
- Counter widths:
  - div_cnt is $clog2(CLK_DIV)+1 bits.
  - With CLK_DIV=1, div_cnt stays 0 and bit_cnt advances every cycle.
  - bit_cnt is 3 bits and never wraps inside a word.

Test Plan:
- Reset, basic LSB-first: rst, then in_data=8'hA5 with in_valid for 1 cycle, CLK_DIV=1, MSB_FIRST=0.
  - select=0,1,…,7 on 8 consecutive cycles; mux output 1,0,1,0,0,1,0,1.
  - bit_last on the 8th cycle; done on the 9th; in_ready=0 during cycles 1–7.
- MSB-first with divider: CLK_DIV=3, MSB_FIRST=1, in_data=8'h81.
  - select=7,7,7,6,6,6,…,0,0,0 (24 bit_valid cycles).
  - Mux output 1 for the first 3 and last 3 cycles, 0 otherwise.
- Back-to-back: send 8'hFF, then hold in_valid with 8'h00; CLK_DIV=1.
  - The second word is accepted on the final cycle of the first; bit_valid stays high for 16 consecutive cycles.
  - done pulses twice, 8 cycles apart.
- Abort: CLK_DIV=2, abort asserted while select=3.
  - Next cycle: bit_valid=0, in_ready=1; no done pulse; a new word is then accepted normally.
- Reset mid-word: rst during bit 5.
  - Next cycle: word=0, select=0, bit_valid=0, done=0.
  - in_ready=0 while rst is held, 1 on the first cycle after release.
- Stalled producer: in_valid held low for 10 cycles after reset.
  - IDLE held, bit_valid=0, in_ready=1, select unchanged.
  - in_data toggling while not accepted does not change word.
